alu_share_arbiter: RTL and testbench

Sequencer and arbiter that shares a single `alu_32bit` instance between two requesters, e.g. the main miniMIPS datapath and an address/branch helper unit. It accepts operation requests, arbitrates round-robin, latches the operands, drives the ALU for one cycle, and registers the result and zero flag. It then holds the result until the winning requester acknowledges it. The block sits between the requesters and the ALU's `res`, `alu_op`, `a`, `b` and `zero` pins.

---
 rtl/alu_share_arbiter_if.sv | 49 ++++
 rtl/alu_share_arbiter.sv | 108 ++++++++++
 tb/tb_alu_share_arbiter.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_share_arbiter_if.sv
// Requester/ALU-side signal bundle for alu_share_arbiter.
// slave: arbiter view; master: requesters plus ALU view.
interface alu_share_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int OPW   = 3
);
  logic             req0;
  logic             req1;
  logic [OPW-1:0]   op0;
  logic [OPW-1:0]   op1;
  logic [WIDTH-1:0] a0;
  logic [WIDTH-1:0] b0;
  logic [WIDTH-1:0] a1;
  logic [WIDTH-1:0] b1;
  logic             gnt0;
  logic             gnt1;
  logic             done0;
  logic             done1;
  logic             ack0;
  logic             ack1;
  logic [WIDTH-1:0] res;
  logic             zero;
  logic             busy;
  logic [OPW-1:0]   alu_op;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [WIDTH-1:0] alu_res;
  logic             alu_zero;

  modport slave (
    input  req0, req1, op0, op1,
    input  a0, b0, a1, b1,
    input  ack0, ack1,
    input  alu_res, alu_zero,
    output gnt0, gnt1, done0, done1,
    output res, zero, busy,
    output alu_op, alu_a, alu_b
  );

  modport master (
    output req0, req1, op0, op1,
    output a0, b0, a1, b1,
    output ack0, ack1,
    output alu_res, alu_zero,
    input  gnt0, gnt1, done0, done1,
    input  res, zero, busy,
    input  alu_op, alu_a, alu_b
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Shares one ALU between two requesters: arbitrate, issue, hold result.
// Ports: clk, rst_n (sync, active-low), bus (alu_share_arbiter_if.slave).
// Option: ALU_ARB_FIXED_PRIO_EN selects fixed priority (req0 wins ties).
module alu_share_arbiter #(
  parameter int WIDTH = 32,
  parameter int OPW   = 3
) (
  input logic                clk,
  input logic                rst_n,
  alu_share_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DONE
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic             owner_q;
  logic [OPW-1:0]   op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic             zero_q;
  logic             win1;
  logic             ack_own;
  logic             cap;

`ifndef ALU_ARB_FIXED_PRIO_EN
  logic last_q;
`endif

  always_comb begin
    state_d = state_q;
    cap     = 1'b0;
`ifdef ALU_ARB_FIXED_PRIO_EN
    win1    = bus.req1 & ~bus.req0;
`else
    // On a tie the requester not granted last time wins.
    win1    = bus.req1 & (~bus.req0 | ~last_q);
`endif
    ack_own = owner_q ? bus.ack1 : bus.ack0;
    unique case (state_q)
      IDLE: begin
        if (bus.req0 | bus.req1) begin
          state_d = ISSUE;
          cap     = 1'b1;
        end
      end
      ISSUE: state_d = DONE;
      DONE: begin
        if (ack_own) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (cap) begin
        owner_q <= win1;
        op_q    <= win1 ? bus.op1 : bus.op0;
        a_q     <= win1 ? bus.a1  : bus.a0;
        b_q     <= win1 ? bus.b1  : bus.b0;
      end
      if (state_q == ISSUE) begin
        res_q  <= bus.alu_res;
        zero_q <= bus.alu_zero;
      end
    end
  end

`ifndef ALU_ARB_FIXED_PRIO_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else if (cap) begin
      last_q <= win1;
    end
  end
`endif

  // Latches only change on capture, so the ALU inputs stay quiet
  // outside ISSUE.
  assign bus.alu_op = op_q;
  assign bus.alu_a  = a_q;
  assign bus.alu_b  = b_q;

  assign bus.gnt0  = (state_q == ISSUE) & ~owner_q;
  assign bus.gnt1  = (state_q == ISSUE) &  owner_q;
  assign bus.done0 = (state_q == DONE)  & ~owner_q;
  assign bus.done1 = (state_q == DONE)  &  owner_q;
  assign bus.busy  = (state_q != IDLE);
  assign bus.res   = res_q;
  assign bus.zero  = zero_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Randomized bench for alu_share_arbiter with an ALU stand-in
// and a transaction-level arbitration/result model.
module tb_alu_share_arbiter;
  localparam int W  = 32;
  localparam int OW = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_share_arbiter_if #(.WIDTH(W), .OPW(OW)) bus();

  alu_share_arbiter #(.WIDTH(W), .OPW(OW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  function automatic logic [31:0] alu_fn(
    input logic [2:0]  op,
    input logic [31:0] a,
    input logic [31:0] b
  );
    logic [31:0] r;
    case (op)
      3'd0: r = a + b;
      3'd1: r = a ^ b;
      3'd2: r = a - b;
      3'd3: r = a * b;
      3'd4: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd5: r = ~(a | b);
      3'd6: r = a & b;
      default: r = a | b;
    endcase
    return r;
  endfunction

  assign bus.alu_res  = alu_fn(bus.alu_op, bus.alu_a, bus.alu_b);
  assign bus.alu_zero = (bus.alu_res == 32'd0);

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  bit          pend [2];
  logic [2:0]  mop  [2];
  logic [31:0] ma   [2];
  logic [31:0] mb   [2];
  int          mlast;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_req(input int r, input logic v);
    if (r == 0) bus.req0 = v;
    else        bus.req1 = v;
  endtask

  task automatic post(input int r, input logic [2:0] op,
                      input logic [31:0] a, input logic [31:0] b);
    pend[r] = 1'b1;
    mop[r] = op;
    ma[r] = a;
    mb[r] = b;
    if (r == 0) begin
      bus.op0 = op; bus.a0 = a; bus.b0 = b;
    end else begin
      bus.op1 = op; bus.a1 = a; bus.b1 = b;
    end
    set_req(r, 1'b1);
  endtask

  task automatic post_rand(input int r);
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    op = 3'($urandom_range(0, 7));
    a  = $urandom;
    b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
    post(r, op, a, b);
  endtask

  task automatic set_ack(input int r, input logic v);
    if (r == 0) bus.ack0 = v;
    else        bus.ack1 = v;
  endtask

  function automatic logic done_of(input int r);
    return (r == 0) ? bus.done0 : bus.done1;
  endfunction

  task automatic serve(input int k, input bit late);
    int w;
    int o;
    logic [31:0] exp;
    if (pend[0] && pend[1]) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      w = 0;
`else
      w = (mlast == 0) ? 1 : 0;
`endif
    end else begin
      w = pend[0] ? 0 : 1;
    end
    o = 1 - w;
    exp = alu_fn(mop[w], ma[w], mb[w]);
    tick();
    chk("gnt0", 32'(bus.gnt0), 32'(w == 0));
    chk("gnt1", 32'(bus.gnt1), 32'(w == 1));
    chk("busy_issue", 32'(bus.busy), 32'd1);
    pend[w] = 1'b0;
    mlast = w;
    set_req(w, 1'b0);
    tick();
    chk("done_own", 32'(done_of(w)), 32'd1);
    chk("done_oth", 32'(done_of(o)), 32'd0);
    chk("res", bus.res, exp);
    chk("zero", 32'(bus.zero), 32'(exp == 32'd0));
    for (int i = 0; i < k; i++) begin
      set_ack(o, 1'($urandom_range(0, 1)));
      if (late && i == 0 && !pend[o]) post_rand(o);
      tick();
      set_ack(o, 1'b0);
      chk("hold_done", 32'(done_of(w)), 32'd1);
      chk("hold_oth", 32'(done_of(o)), 32'd0);
      chk("hold_gnt", 32'({bus.gnt0, bus.gnt1}), 32'd0);
      chk("hold_res", bus.res, exp);
    end
    set_ack(w, 1'b1);
    tick();
    set_ack(w, 1'b0);
    chk("idle_busy", 32'(bus.busy), 32'd0);
    chk("idle_done", 32'({bus.done0, bus.done1}), 32'd0);
    chk("idle_res", bus.res, exp);
  endtask

  task automatic drain();
    for (int i = 0; i < 4 && (pend[0] || pend[1]); i++)
      serve(0, 1'b0);
  endtask

  initial begin
    bus.req0 = 0; bus.req1 = 0;
    bus.op0 = 0; bus.op1 = 0;
    bus.a0 = 0; bus.b0 = 0;
    bus.a1 = 0; bus.b1 = 0;
    bus.ack0 = 0; bus.ack1 = 0;
    pend[0] = 0; pend[1] = 0;
    mlast = 1;
    rst_n = 1'b0;
    tick();
    tick();
    chk("rst_res", bus.res, 32'd0);
    chk("rst_zero", 32'(bus.zero), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_gnt", 32'({bus.gnt0, bus.gnt1}), 32'd0);
    chk("rst_done", 32'({bus.done0, bus.done1}), 32'd0);
    chk("rst_op", 32'(bus.alu_op), 32'd0);
    chk("rst_a", bus.alu_a, 32'd0);
    chk("rst_b", bus.alu_b, 32'd0);
    rst_n = 1'b1;
    tick();

    post(0, 3'd0, 32'd13, 32'd12);
    serve(0, 1'b0);
    post(1, 3'd2, 32'h8000000D, 32'h8000000D);
    serve(2, 1'b0);

    post(0, 3'd1, 32'h0200000D, 32'h0200000C);
    post(1, 3'd4, 32'h0200000D, 32'h2200000C);
    serve(0, 1'b0);
    if (!pend[0]) post(0, 3'd1, 32'h0200000D, 32'h0200000C);
    serve(0, 1'b0);
    if (!pend[0]) post(0, 3'd1, 32'h0200000D, 32'h0200000C);
    if (!pend[1]) post(1, 3'd4, 32'h0200000D, 32'h2200000C);
    serve(0, 1'b0);
    drain();

    post(0, 3'd3, 32'd13, 32'd12);
    serve(5, 1'b1);
    drain();

    post(0, 3'd6, 32'h0200000D, 32'h0200000C);
    tick();
    chk("mid_gnt0", 32'(bus.gnt0), 32'd1);
    rst_n = 1'b0;
    bus.req0 = 1'b0;
    pend[0] = 1'b0;
    tick();
    rst_n = 1'b1;
    mlast = 1;
    chk("mid_busy", 32'(bus.busy), 32'd0);
    chk("mid_res", bus.res, 32'd0);
    chk("mid_zero", 32'(bus.zero), 32'd0);
    chk("mid_done", 32'({bus.done0, bus.done1}), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mid_nodone", 32'({bus.done0, bus.done1}), 32'd0);
    end

    for (int n = 0; n < 200; n++) begin
      for (int r = 0; r < 2; r++)
        if (!pend[r] && $urandom_range(0, 1) == 1) post_rand(r);
      if (!pend[0] && !pend[1]) post_rand($urandom_range(0, 1));
      serve($urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule
